// File: rtl/axi_err_tracker.sv
// axi_err_tracker
// Passive AXI4(+ATOP) error tracker. Watches handshakes on one AXI port, keeps
// a FIFO of request addresses per (direction, ID), pairs every B / R-last with
// its request, and logs error responses and per-transaction timeouts into a
// shared error queue that is drained through a valid/ready pop interface.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   aw_* / ar_* / b_* / r_*         observed channel handshakes and fields
//   err_valid_o / err_ready_i       error record available / pop
//   err_kind_o                      0 B err, 1 R err, 2 write timeout, 3 read timeout
//   err_id_o, err_addr_o, err_resp_o  record contents (zero when queue empty)
//   drop_cnt_o                      saturating count of lost records
//   track_ovf_o, unexp_rsp_o        sticky status flags
//   irq_o                           mirrors err_valid_o
module axi_err_tracker #(
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned IdWidth         = 2,
    parameter int unsigned NumOutstanding  = 4,
    parameter int unsigned NumStoredErrors = 4,
    parameter int unsigned TimeoutCycles   = 0,
    parameter bit          DropOldest      = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_hs_i,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [5:0]           aw_atop_i,
    input  logic                 ar_hs_i,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic                 b_hs_i,
    input  logic [IdWidth-1:0]   b_id_i,
    input  logic [1:0]           b_resp_i,
    input  logic                 r_hs_i,
    input  logic [IdWidth-1:0]   r_id_i,
    input  logic [1:0]           r_resp_i,
    input  logic                 r_last_i,
    output logic                 err_valid_o,
    input  logic                 err_ready_i,
    output logic [1:0]           err_kind_o,
    output logic [IdWidth-1:0]   err_id_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [1:0]           err_resp_o,
    output logic [7:0]           drop_cnt_o,
    output logic                 track_ovf_o,
    output logic                 unexp_rsp_o,
    output logic                 irq_o
);
    localparam int unsigned NumIds = 2 ** IdWidth;
    // Queue index = {direction, id}: write queues first, then read queues.
    localparam int unsigned NumQ   = 2 * NumIds;
    localparam int unsigned PtrW   = $clog2(NumOutstanding);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned TmrW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned EqPtrW = (NumStoredErrors > 1) ? $clog2(NumStoredErrors) : 1;
    localparam int unsigned EqCntW = $clog2(NumStoredErrors + 1);
    localparam logic [TmrW-1:0] TmrLoad = TmrW'(TimeoutCycles);

    // Tracking state. The head-age timer counts down from TimeoutCycles; zero
    // means the head has been outstanding for at least TimeoutCycles.
    logic [AddrWidth-1:0] q_mem [NumQ][NumOutstanding];
    logic [PtrW-1:0]      q_rd  [NumQ];
    logic [PtrW-1:0]      q_wr  [NumQ];
    logic [CntW-1:0]      q_cnt [NumQ];
    logic [TmrW-1:0]      q_tmr [NumQ];
    logic [NumQ-1:0]      q_rep;
    logic [NumIds-1:0]    rl_vld;
    logic [1:0]           rl_resp [NumIds];
    logic                 track_ovf_q, unexp_q;

    logic [1:0]           q_npush [NumQ];
    logic [1:0]           q_nacc  [NumQ];
    logic [AddrWidth-1:0] q_a0    [NumQ];
    logic [AddrWidth-1:0] q_a1    [NumQ];
    logic [AddrWidth-1:0] q_head  [NumQ];
    logic [NumQ-1:0]      q_pop, q_nonempty, q_to_req, q_grant;
    logic [IdWidth:0]     wq_b, rq_r;
    logic                 b_ok, r_ok, b_req, r_req, r_err, ovf_set, unexp_set, lost;
    logic [1:0]           r_rsp;
    logic                 rec_vld;
    logic [1:0]           rec_kind, rec_resp;
    logic [IdWidth-1:0]   rec_id;
    logic [AddrWidth-1:0] rec_addr;
    int                   cap;

    // Error queue.
    logic [1:0]           eq_kind [NumStoredErrors];
    logic [IdWidth-1:0]   eq_id   [NumStoredErrors];
    logic [AddrWidth-1:0] eq_addr [NumStoredErrors];
    logic [1:0]           eq_resp [NumStoredErrors];
    logic [EqPtrW-1:0]    eq_rd, eq_wr;
    logic [EqCntW-1:0]    eq_cnt;
    logic [7:0]           drop_cnt_q;
    logic                 eq_pop, eq_full, eq_drop, eq_wen;
    logic [8:0]           drop_sum;

    logic unused_atop;
    assign unused_atop = ^aw_atop_i[4:0];

    function automatic logic [EqPtrW-1:0] eq_inc(input logic [EqPtrW-1:0] p);
        return (p == EqPtrW'(NumStoredErrors - 1)) ? '0 : p + EqPtrW'(1);
    endfunction

    always_comb begin
        q_pop    = '0;
        q_grant  = '0;
        for (int q = 0; q < NumQ; q++) begin
            q_npush[q]    = 2'd0;
            q_a0[q]       = aw_addr_i;
            q_a1[q]       = aw_addr_i;
            q_nonempty[q] = (q_cnt[q] != '0);
            q_head[q]     = q_mem[q][q_rd[q]];
            q_to_req[q]   = (TimeoutCycles > 0) && q_nonempty[q] && (q_tmr[q] == '0) && !q_rep[q];
        end
        for (int i = 0; i < NumIds; i++) begin
            if (aw_hs_i && aw_id_i == IdWidth'(i)) q_npush[i] = 2'd1;
            q_pop[i]          = b_hs_i && (b_id_i == IdWidth'(i)) && q_nonempty[i];
            q_pop[NumIds + i] = r_hs_i && r_last_i && (r_id_i == IdWidth'(i)) && q_nonempty[NumIds + i];
            // An AR and an atomic AW on the same read ID in one cycle: AR is queued first.
            if (ar_hs_i && ar_id_i == IdWidth'(i)) begin
                q_npush[NumIds + i] = 2'd1;
                q_a0[NumIds + i]    = ar_addr_i;
            end
            if (aw_hs_i && aw_atop_i[5] && aw_id_i == IdWidth'(i)) begin
                if (q_npush[NumIds + i] == 2'd1) begin
                    q_npush[NumIds + i] = 2'd2;
                    q_a1[NumIds + i]    = aw_addr_i;
                end else begin
                    q_npush[NumIds + i] = 2'd1;
                end
            end
        end
        // A same-cycle pop frees a slot for the incoming push.
        ovf_set = 1'b0;
        cap     = 0;
        for (int q = 0; q < NumQ; q++) begin
            cap = int'(NumOutstanding) - int'(q_cnt[q]) + (q_pop[q] ? 1 : 0);
            if (int'(q_npush[q]) <= cap) q_nacc[q] = q_npush[q];
            else                         q_nacc[q] = 2'(cap);
            if (q_nacc[q] != q_npush[q]) ovf_set = 1'b1;
        end

        wq_b      = {1'b0, b_id_i};
        rq_r      = {1'b1, r_id_i};
        b_ok      = b_hs_i && q_nonempty[wq_b];
        r_ok      = r_hs_i && q_nonempty[rq_r];
        unexp_set = (b_hs_i && !b_ok) || (r_hs_i && !r_ok);
        b_req     = b_ok && b_resp_i[1];
        r_err     = rl_vld[r_id_i] || r_resp_i[1];
        r_rsp     = rl_vld[r_id_i] ? rl_resp[r_id_i] : r_resp_i;
        r_req     = r_ok && r_last_i && r_err;

        rec_vld  = 1'b0;
        rec_kind = 2'd0;
        rec_id   = '0;
        rec_addr = '0;
        rec_resp = 2'd0;
        lost     = 1'b0;
        if (b_req) begin
            rec_vld  = 1'b1;
            rec_id   = b_id_i;
            rec_addr = q_head[wq_b];
            rec_resp = b_resp_i;
            lost     = r_req;
        end else if (r_req) begin
            rec_vld  = 1'b1;
            rec_kind = 2'd1;
            rec_id   = r_id_i;
            rec_addr = q_head[rq_r];
            rec_resp = r_rsp;
        end else begin
            // Fixed priority: write queues before read queues, lowest ID first.
            for (int q = 0; q < NumQ; q++) begin
                if (q_to_req[q] && !rec_vld) begin
                    rec_vld    = 1'b1;
                    rec_kind   = (q < NumIds) ? 2'd2 : 2'd3;
                    rec_id     = IdWidth'(q % NumIds);
                    rec_addr   = q_head[q];
                    q_grant[q] = 1'b1;
                end
            end
        end

        eq_pop   = (eq_cnt != '0) && err_ready_i;
        eq_full  = (eq_cnt == EqCntW'(NumStoredErrors));
        eq_drop  = rec_vld && eq_full && !eq_pop;
        eq_wen   = rec_vld && (!eq_full || eq_pop || DropOldest);
        drop_sum = {1'b0, drop_cnt_q} + {8'd0, lost} + {8'd0, eq_drop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int q = 0; q < NumQ; q++) begin
                q_rd[q]  <= '0;
                q_wr[q]  <= '0;
                q_cnt[q] <= '0;
                q_tmr[q] <= TmrLoad;
            end
            for (int i = 0; i < NumIds; i++) rl_resp[i] <= 2'd0;
            q_rep       <= '0;
            rl_vld      <= '0;
            track_ovf_q <= 1'b0;
            unexp_q     <= 1'b0;
            eq_rd       <= '0;
            eq_wr       <= '0;
            eq_cnt      <= '0;
            drop_cnt_q  <= 8'd0;
        end else begin
            for (int q = 0; q < NumQ; q++) begin
                q_wr[q]  <= q_wr[q] + PtrW'(q_nacc[q]);
                q_rd[q]  <= q_rd[q] + PtrW'(q_pop[q]);
                q_cnt[q] <= q_cnt[q] + CntW'(q_nacc[q]) - CntW'(q_pop[q]);
                if (q_pop[q] || (!q_nonempty[q] && q_nacc[q] != 2'd0)) q_tmr[q] <= TmrLoad;
                else if (q_nonempty[q] && q_tmr[q] != '0)               q_tmr[q] <= q_tmr[q] - TmrW'(1);
                if (q_pop[q])        q_rep[q] <= 1'b0;
                else if (q_grant[q]) q_rep[q] <= 1'b1;
            end
            if (r_ok) begin
                if (r_last_i) begin
                    rl_vld[r_id_i] <= 1'b0;
                end else if (!rl_vld[r_id_i] && r_resp_i[1]) begin
                    rl_vld[r_id_i]  <= 1'b1;
                    rl_resp[r_id_i] <= r_resp_i;
                end
            end
            if (ovf_set)   track_ovf_q <= 1'b1;
            if (unexp_set) unexp_q     <= 1'b1;

            if (rec_vld && (!eq_full || eq_pop)) begin
                eq_wr <= eq_inc(eq_wr);
                if (eq_pop) eq_rd  <= eq_inc(eq_rd);
                else        eq_cnt <= eq_cnt + EqCntW'(1);
            end else if (rec_vld && DropOldest) begin
                // Full: write and read pointers coincide, so the oldest slot is overwritten.
                eq_wr <= eq_inc(eq_wr);
                eq_rd <= eq_inc(eq_rd);
            end else if (eq_pop) begin
                eq_rd  <= eq_inc(eq_rd);
                eq_cnt <= eq_cnt - EqCntW'(1);
            end
            drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int q = 0; q < NumQ; q++) begin
            if (q_nacc[q] != 2'd0) q_mem[q][q_wr[q]] <= q_a0[q];
            if (q_nacc[q] == 2'd2) q_mem[q][q_wr[q] + PtrW'(1)] <= q_a1[q];
        end
        if (eq_wen) begin
            eq_kind[eq_wr] <= rec_kind;
            eq_id[eq_wr]   <= rec_id;
            eq_addr[eq_wr] <= rec_addr;
            eq_resp[eq_wr] <= rec_resp;
        end
    end

    assign err_valid_o = (eq_cnt != '0);
    assign err_kind_o  = err_valid_o ? eq_kind[eq_rd] : 2'd0;
    assign err_id_o    = err_valid_o ? eq_id[eq_rd]   : '0;
    assign err_addr_o  = err_valid_o ? eq_addr[eq_rd] : '0;
    assign err_resp_o  = err_valid_o ? eq_resp[eq_rd] : 2'd0;
    assign drop_cnt_o  = drop_cnt_q;
    assign track_ovf_o = track_ovf_q;
    assign unexp_rsp_o = unexp_q;
    assign irq_o       = err_valid_o;

endmodule

// File: tb/tb_axi_err_tracker.sv
// Testbench for axi_err_tracker. Two instances share all stimulus: one keeps
// the oldest records when its error queue is full, the other overwrites them.
module tb_axi_err_tracker;
    localparam int AW  = 32;
    localparam int IW  = 2;
    localparam int NO  = 4;
    localparam int NSE = 2;
    localparam int TO  = 8;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  id;
        logic [31:0] addr;
        logic [1:0]  resp;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        aw_hs = 1'b0, ar_hs = 1'b0, b_hs = 1'b0, r_hs = 1'b0, r_last = 1'b0;
    logic [1:0]  aw_id = '0, ar_id = '0, b_id = '0, r_id = '0, b_resp = '0, r_resp = '0;
    logic [31:0] aw_addr = '0, ar_addr = '0;
    logic [5:0]  aw_atop = '0;
    logic        err_ready = 1'b0;

    logic [1:0]        ev, tovf, unx, irq;
    logic [1:0][1:0]   ek, ei, er;
    logic [1:0][31:0]  ea;
    logic [1:0][7:0]   dc;

    axi_err_tracker #(.AddrWidth(AW), .IdWidth(IW), .NumOutstanding(NO), .NumStoredErrors(NSE),
                      .TimeoutCycles(TO), .DropOldest(1'b0)) u_dut_keep (
        .clk_i(clk), .rst_i(rst),
        .aw_hs_i(aw_hs), .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_atop_i(aw_atop),
        .ar_hs_i(ar_hs), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .b_hs_i(b_hs), .b_id_i(b_id), .b_resp_i(b_resp),
        .r_hs_i(r_hs), .r_id_i(r_id), .r_resp_i(r_resp), .r_last_i(r_last),
        .err_valid_o(ev[0]), .err_ready_i(err_ready), .err_kind_o(ek[0]), .err_id_o(ei[0]),
        .err_addr_o(ea[0]), .err_resp_o(er[0]), .drop_cnt_o(dc[0]), .track_ovf_o(tovf[0]),
        .unexp_rsp_o(unx[0]), .irq_o(irq[0]));

    axi_err_tracker #(.AddrWidth(AW), .IdWidth(IW), .NumOutstanding(NO), .NumStoredErrors(NSE),
                      .TimeoutCycles(TO), .DropOldest(1'b1)) u_dut_ovr (
        .clk_i(clk), .rst_i(rst),
        .aw_hs_i(aw_hs), .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_atop_i(aw_atop),
        .ar_hs_i(ar_hs), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .b_hs_i(b_hs), .b_id_i(b_id), .b_resp_i(b_resp),
        .r_hs_i(r_hs), .r_id_i(r_id), .r_resp_i(r_resp), .r_last_i(r_last),
        .err_valid_o(ev[1]), .err_ready_i(err_ready), .err_kind_o(ek[1]), .err_id_o(ei[1]),
        .err_addr_o(ea[1]), .err_resp_o(er[1]), .drop_cnt_o(dc[1]), .track_ovf_o(tovf[1]),
        .unexp_rsp_o(unx[1]), .irq_o(irq[1]));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queues indexed dir*4+id (dir 0 write, 1 read).
    logic [31:0] mq [8][$];
    int          age [8];
    bit          rep [8];
    bit          lat_v [4];
    logic [1:0]  lat_r [4];
    bit          m_ovf, m_unexp;
    rec_t        meq [2][$];
    int          mdrop [2];

    task automatic model_reset();
        for (int q = 0; q < 8; q++) begin
            mq[q].delete();
            age[q] = 0;
            rep[q] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            lat_v[i] = 1'b0;
            lat_r[i] = 2'd0;
        end
        m_ovf = 1'b0;
        m_unexp = 1'b0;
        for (int p = 0; p < 2; p++) begin
            meq[p].delete();
            mdrop[p] = 0;
        end
    endtask

    task automatic m_push(input int q, input logic [31:0] a);
        if (mq[q].size() < NO) mq[q].push_back(a);
        else m_ovf = 1'b1;
    endtask

    task automatic model_step();
        bit   to_pend [8];
        bit   grant [8];
        bit   popq [8];
        int   pre_sz [8];
        bit   b_ok, r_ok, b_req, r_req, err, rec_v, pop_e;
        logic [1:0] rrsp;
        rec_t rec;
        int   lost;
        if (rst) begin
            model_reset();
            return;
        end
        for (int q = 0; q < 8; q++) begin
            pre_sz[q]  = mq[q].size();
            to_pend[q] = (pre_sz[q] > 0) && (age[q] >= TO) && !rep[q];
            grant[q]   = 1'b0;
            popq[q]    = 1'b0;
        end
        b_ok = b_hs && (pre_sz[int'(b_id)] > 0);
        r_ok = r_hs && (pre_sz[4 + int'(r_id)] > 0);
        if ((b_hs && !b_ok) || (r_hs && !r_ok)) m_unexp = 1'b1;
        b_req = b_ok && b_resp[1];
        r_req = 1'b0;
        rrsp  = 2'd0;
        if (r_ok) begin
            rrsp = lat_v[r_id] ? lat_r[r_id] : r_resp;
            err  = lat_v[r_id] || r_resp[1];
            if (r_last) begin
                r_req = err;
                lat_v[r_id] = 1'b0;
            end else if (!lat_v[r_id] && r_resp[1]) begin
                lat_v[r_id] = 1'b1;
                lat_r[r_id] = r_resp;
            end
        end
        rec = '0;
        rec_v = 1'b0;
        lost = 0;
        if (b_req) begin
            rec_v = 1'b1; rec.kind = 2'd0; rec.id = b_id; rec.addr = mq[int'(b_id)][0]; rec.resp = b_resp;
            if (r_req) lost = 1;
        end else if (r_req) begin
            rec_v = 1'b1; rec.kind = 2'd1; rec.id = r_id; rec.addr = mq[4 + int'(r_id)][0]; rec.resp = rrsp;
        end else begin
            for (int q = 0; q < 8; q++) begin
                if (to_pend[q] && !rec_v) begin
                    rec_v = 1'b1; grant[q] = 1'b1;
                    rec.kind = (q < 4) ? 2'd2 : 2'd3; rec.id = 2'(q % 4); rec.addr = mq[q][0]; rec.resp = 2'd0;
                end
            end
        end
        popq[int'(b_id)]     = b_ok;
        popq[4 + int'(r_id)] = r_ok && r_last;
        for (int q = 0; q < 8; q++) if (popq[q]) void'(mq[q].pop_front());
        if (aw_hs) m_push(int'(aw_id), aw_addr);
        if (ar_hs) m_push(4 + int'(ar_id), ar_addr);
        if (aw_hs && aw_atop[5]) m_push(4 + int'(aw_id), aw_addr);
        for (int q = 0; q < 8; q++) begin
            if (popq[q] || (pre_sz[q] == 0 && mq[q].size() > 0)) age[q] = 0;
            else if (pre_sz[q] > 0 && age[q] < TO) age[q] = age[q] + 1;
            if (popq[q]) rep[q] = 1'b0;
            else if (grant[q]) rep[q] = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            pop_e = err_ready && (meq[p].size() > 0);
            mdrop[p] += lost;
            if (rec_v) begin
                if (meq[p].size() < NSE || pop_e) begin
                    if (pop_e) void'(meq[p].pop_front());
                    meq[p].push_back(rec);
                end else begin
                    mdrop[p] += 1;
                    if (p == 1) begin
                        void'(meq[p].pop_front());
                        meq[p].push_back(rec);
                    end
                end
            end else if (pop_e) begin
                void'(meq[p].pop_front());
            end
            if (mdrop[p] > 255) mdrop[p] = 255;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        aw_hs = 1'b0; ar_hs = 1'b0; b_hs = 1'b0; r_hs = 1'b0; r_last = 1'b0;
        aw_atop = '0; b_resp = '0; r_resp = '0; err_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            n_vec++;
            if ({ev[p], ek[p], ei[p], ea[p], er[p], dc[p], tovf[p], unx[p], irq[p]} !== '0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got v=%0b k=%0d id=%0d a=%h r=%0d drop=%0d ovf=%0b unexp=%0b irq=%0b, expected all zero",
                         p, ev[p], ek[p], ei[p], ea[p], er[p], dc[p], tovf[p], unx[p], irq[p]);
            end
        end
    endtask

    task automatic test_b_error();
        do_reset();
        aw_hs = 1'b1; aw_id = 2'd1; aw_addr = 32'h1000; tick(); idle();
        b_hs = 1'b1; b_id = 2'd1; b_resp = 2'b10; tick(); idle();
        for (int p = 0; p < 2; p++) begin
            n_vec++;
            if ({ev[p], irq[p], ek[p], ei[p], ea[p], er[p]} !== {1'b1, 1'b1, 2'd0, 2'd1, 32'h1000, 2'd2}) begin
                n_bad++;
                $display("FAIL b_error_rec dut%0d: got v=%0b irq=%0b k=%0d id=%0d a=%h r=%0d, expected 1 1 0 1 00001000 2",
                         p, ev[p], irq[p], ek[p], ei[p], ea[p], er[p]);
            end
        end
        err_ready = 1'b1; tick(); idle();
        n_vec++;
        if (ev !== 2'b00) begin
            n_bad++;
            $display("FAIL b_error_pop: got valid=%b, expected 00", ev);
        end
    endtask

    task automatic test_r_burst();
        do_reset();
        ar_hs = 1'b1; ar_id = 2'd2; ar_addr = 32'h2000; tick(); idle();
        for (int beat = 1; beat <= 4; beat++) begin
            r_hs = 1'b1; r_id = 2'd2; r_resp = (beat == 1) ? 2'b11 : 2'b00; r_last = (beat == 4);
            tick(); idle();
            if (beat < 4) begin
                n_vec++;
                if (ev !== 2'b00) begin
                    n_bad++;
                    $display("FAIL r_burst_early beat%0d: got valid=%b, expected 00", beat, ev);
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            n_vec++;
            if ({ev[p], ek[p], ei[p], ea[p], er[p]} !== {1'b1, 2'd1, 2'd2, 32'h2000, 2'd3}) begin
                n_bad++;
                $display("FAIL r_burst_rec dut%0d: got v=%0b k=%0d id=%0d a=%h r=%0d, expected 1 1 2 00002000 3",
                         p, ev[p], ek[p], ei[p], ea[p], er[p]);
            end
        end
        err_ready = 1'b1; tick(); idle();
        n_vec++;
        if (ev !== 2'b00) begin
            n_bad++;
            $display("FAIL r_burst_single: got valid=%b after one pop, expected 00", ev);
        end
    endtask

    task automatic test_timeout();
        int waited;
        int extra;
        do_reset();
        ar_hs = 1'b1; ar_id = 2'd0; ar_addr = 32'h40; tick(); idle();
        waited = 0;
        for (int c = 1; c <= 20 && waited == 0; c++) begin
            tick();
            if (ev[0]) waited = c;
        end
        // Age reaches 8 eight cycles after the push; the record lands one cycle later.
        n_vec++;
        if (waited != 9) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles (0 = none within 20), expected 9", waited);
        end
        for (int p = 0; p < 2; p++) begin
            n_vec++;
            if ({ev[p], ek[p], ei[p], ea[p], er[p]} !== {1'b1, 2'd3, 2'd0, 32'h40, 2'd0}) begin
                n_bad++;
                $display("FAIL timeout_rec dut%0d: got v=%0b k=%0d id=%0d a=%h r=%0d, expected 1 3 0 00000040 0",
                         p, ev[p], ek[p], ei[p], ea[p], er[p]);
            end
        end
        err_ready = 1'b1; tick(); idle();
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ev != 2'b00) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL timeout_repeat: got %0d cycles with a record, expected 0", extra);
        end
        r_hs = 1'b1; r_id = 2'd0; r_resp = 2'b00; r_last = 1'b1; tick(); idle();
        n_vec++;
        if ({ev, unx} !== 4'b0000) begin
            n_bad++;
            $display("FAIL timeout_late_rsp: got valid=%b unexp=%b, expected 00 00", ev, unx);
        end
        r_hs = 1'b1; r_id = 2'd0; r_last = 1'b1; tick(); idle();
        n_vec++;
        if (unx !== 2'b11) begin
            n_bad++;
            $display("FAIL timeout_popped: got unexp=%b on second R, expected 11", unx);
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            aw_hs = 1'b1; aw_id = 2'd0; aw_addr = 32'(k * 32'h100); tick();
        end
        idle();
        for (int k = 1; k <= 3; k++) begin
            b_hs = 1'b1; b_id = 2'd0; b_resp = 2'b10; tick();
        end
        idle();
        n_vec++;
        if ({ea[0], dc[0], ea[1], dc[1]} !== {32'h100, 8'd1, 32'h200, 8'd1}) begin
            n_bad++;
            $display("FAIL drop_full: got keep a=%h drop=%0d ovr a=%h drop=%0d, expected 00000100 1 00000200 1",
                     ea[0], dc[0], ea[1], dc[1]);
        end
        err_ready = 1'b1; tick(); idle();
        n_vec++;
        if ({ev, ea[0], ea[1]} !== {2'b11, 32'h200, 32'h300}) begin
            n_bad++;
            $display("FAIL drop_second: got v=%b keep a=%h ovr a=%h, expected 11 00000200 00000300", ev, ea[0], ea[1]);
        end
        err_ready = 1'b1; tick(); idle();
        n_vec++;
        if (ev !== 2'b00) begin
            n_bad++;
            $display("FAIL drop_drained: got valid=%b, expected 00", ev);
        end
    endtask

    task automatic test_overflow_unexp();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            aw_hs = 1'b1; aw_id = 2'd3; aw_addr = 32'(k * 16); tick();
            if (k >= 4) begin
                n_vec++;
                if (tovf !== ((k == 5) ? 2'b11 : 2'b00)) begin
                    n_bad++;
                    $display("FAIL track_ovf after AW %0d: got %b, expected %b", k, tovf, (k == 5) ? 2'b11 : 2'b00);
                end
            end
        end
        idle();
        b_hs = 1'b1; b_id = 2'd0; b_resp = 2'b00; tick(); idle();
        n_vec++;
        if ({unx, ev, tovf} !== 6'b110011) begin
            n_bad++;
            $display("FAIL unexp_rsp: got unexp=%b valid=%b ovf=%b, expected 11 00 11", unx, ev, tovf);
        end
    endtask

    task automatic test_collision();
        do_reset();
        aw_hs = 1'b1; aw_id = 2'd0; aw_addr = 32'h500;
        ar_hs = 1'b1; ar_id = 2'd1; ar_addr = 32'h600; tick(); idle();
        b_hs = 1'b1; b_id = 2'd0; b_resp = 2'b10;
        r_hs = 1'b1; r_id = 2'd1; r_resp = 2'b10; r_last = 1'b1; tick(); idle();
        for (int p = 0; p < 2; p++) begin
            n_vec++;
            if ({ev[p], ek[p], ea[p], dc[p]} !== {1'b1, 2'd0, 32'h500, 8'd1}) begin
                n_bad++;
                $display("FAIL collision dut%0d: got v=%0b k=%0d a=%h drop=%0d, expected 1 0 00000500 1",
                         p, ev[p], ek[p], ea[p], dc[p]);
            end
        end
        err_ready = 1'b1; tick(); idle();
        n_vec++;
        if (ev !== 2'b00) begin
            n_bad++;
            $display("FAIL collision_single: got valid=%b, expected 00", ev);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        aw_hs = 1'b1; aw_id = 2'd2; aw_addr = 32'h700; tick(); idle();
        rst = 1'b1; tick(); rst = 1'b0;
        b_hs = 1'b1; b_id = 2'd2; b_resp = 2'b10; tick(); idle();
        n_vec++;
        if ({ev, unx, dc[0], dc[1]} !== {2'b00, 2'b11, 8'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL mid_reset: got valid=%b unexp=%b drop=%0d/%0d, expected 00 11 0/0", ev, unx, dc[0], dc[1]);
        end
    endtask

    task automatic test_random();
        rec_t e;
        bit   ev_exp;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst       = ($urandom_range(0, 499) == 0);
            aw_hs     = ($urandom_range(0, 9) < 3);
            aw_id     = 2'($urandom_range(0, 3));
            aw_addr   = $urandom;
            aw_atop   = ($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00;
            ar_hs     = ($urandom_range(0, 9) < 3);
            ar_id     = 2'($urandom_range(0, 3));
            ar_addr   = $urandom;
            b_hs      = ($urandom_range(0, 9) < 3);
            b_id      = 2'($urandom_range(0, 3));
            b_resp    = 2'($urandom_range(0, 3));
            r_hs      = ($urandom_range(0, 9) < 4);
            r_id      = 2'($urandom_range(0, 3));
            r_resp    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'd0;
            r_last    = ($urandom_range(0, 1) == 1);
            err_ready = ($urandom_range(0, 9) < 4);
            tick();
            for (int p = 0; p < 2; p++) begin
                ev_exp = (meq[p].size() > 0);
                if (ev_exp) e = meq[p][0];
                else e = '0;
                n_vec++;
                if ({ev[p], ek[p], ei[p], ea[p], er[p], dc[p], tovf[p], unx[p], irq[p]} !==
                    {ev_exp, e.kind, e.id, e.addr, e.resp, 8'(mdrop[p]), m_ovf, m_unexp, ev_exp}) begin
                    n_bad++;
                    $display("FAIL random dut%0d cyc %0d: got v=%0b k=%0d id=%0d a=%h r=%0d drop=%0d ovf=%0b unexp=%0b irq=%0b, expected v=%0b k=%0d id=%0d a=%h r=%0d drop=%0d ovf=%0b unexp=%0b",
                             p, cyc, ev[p], ek[p], ei[p], ea[p], er[p], dc[p], tovf[p], unx[p], irq[p],
                             ev_exp, e.kind, e.id, e.addr, e.resp, mdrop[p], m_ovf, m_unexp);
                end
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_b_error();
        test_r_burst();
        test_timeout();
        test_drop();
        test_overflow_unexp();
        test_collision();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_err_tracker.md
Name: axi_err_tracker

Overview:
- Next-generation AXI bus error tracker. Passively observes one AXI4(+ATOP) port.
- Tracks outstanding write and read transactions per ID, pairs each response with its request address, and logs error responses and per-transaction timeouts into one shared error queue.
- The queue is drained through a valid/ready pop interface and raises an interrupt.
- Sits beside a manager/subordinate pair, e.g. between a core and its crossbar port.

Parameters:
- AddrWidth, 32: request address width.
- IdWidth, 2: AXI ID width; NumIds = 2**IdWidth tracked channels per direction.
- NumOutstanding, 4: tracked transactions per ID per direction (power of 2, ≥2).
- NumStoredErrors, 4: error queue depth (≥1).
- TimeoutCycles, 0: cycles a transaction may be outstanding before a timeout is logged; 0 disables timeouts.
- DropOldest, 0: 1 = overwrite the oldest record when the queue is full; 0 = discard the new record.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- aw_hs_i  in  1  AW handshake (valid & ready).
- aw_id_i  in  IdWidth  AW ID.
- aw_addr_i  in  AddrWidth  AW address.
- aw_atop_i  in  6  AW ATOP.
- ar_hs_i  in  1  AR handshake.
- ar_id_i  in  IdWidth  AR ID.
- ar_addr_i  in  AddrWidth  AR address.
- b_hs_i  in  1  B handshake.
- b_id_i  in  IdWidth  B ID.
- b_resp_i  in  2  B response.
- r_hs_i  in  1  R handshake.
- r_id_i  in  IdWidth  R ID.
- r_resp_i  in  2  R response.
- r_last_i  in  1  R last.
- err_valid_o  out  1  error record available.
- err_ready_i  in  1  pop error record.
- err_kind_o  out  2  0 = B error, 1 = R error, 2 = write timeout, 3 = read timeout.
- err_id_o  out  IdWidth  ID of the erroring transaction.
- err_addr_o  out  AddrWidth  request address.
- err_resp_o  out  2  response code (2'b00 for timeouts).
- drop_cnt_o  out  8  saturating count of lost records.
- track_ovf_o  out  1  sticky: a request was not tracked because its queue was full.
- unexp_rsp_o  out  1  sticky: response arrived on an ID with an empty queue.
- irq_o  out  1  equals err_valid_o.

Behaviour:
- Reset: all tracking queues empty; error queue empty; all outputs 0. Reset mid-operation discards all state, including in-flight transactions; their later responses set unexp_rsp_o.
- Tracking: one FIFO of addresses per (direction, ID).
  - aw_hs_i pushes to the write queue of aw_id_i.
  - ar_hs_i pushes to the read queue of ar_id_i.
  - aw_hs_i with aw_atop_i[5]=1 (atomic with R data) additionally pushes to the read queue of aw_id_i.
  - Push into a full queue: entry dropped, track_ovf_o set.
- Write response: b_hs_i pops the head of write queue b_id_i. If b_resp_i[1]=1 (SLVERR/DECERR), a kind-0 record {id, head addr, resp} is requested.
- Read response:
  - Per read ID, the first erroring beat latches its resp.
  - The entry is popped only on r_hs_i & r_last_i.
  - If any beat of the burst errored, a kind-1 record with the latched resp is requested at the last beat; the latch then clears.
- Response to an empty queue (including a same-cycle push to that empty queue): no pop, no record, unexp_rsp_o set.
- Same-cycle push and pop on a non-empty queue: both take effect; occupancy unchanged.
- Timeouts (TimeoutCycles>0):
  - Each queue has a head-age counter, cleared on every pop and on push into an empty queue, otherwise incremented while non-empty, saturating.
  - At age ≥ TimeoutCycles with the head's reported flag clear, a kind-2/3 record with resp 0 is requested.
  - The flag is set only when the record is accepted. The entry stays queued; its later response is still checked.
- Log arbitration: at most one record enters the error queue per cycle. Priority: B error > R error > timeouts (writes before reads, lowest ID first).
  - A losing B/R error request is lost: drop_cnt_o += 1, per competing request.
  - A losing timeout stays pending and retries next cycle.
- Error queue: record written the cycle after the event; err_valid_o is asserted 1 cycle after the triggering handshake.
  - Pop on err_valid_o & err_ready_i. Outputs show the oldest record.
  - Full with no pop: DropOldest=1 discards the oldest and enqueues the new; DropOldest=0 discards the new. Either way drop_cnt_o += 1.
  - Full with a same-cycle pop: no drop.
  - drop_cnt_o saturates at 255.
- Sticky flags clear only on reset.

Test Plan:
- AW id=1 addr=0x1000, then B id=1 resp=2'b10 → next cycle err_valid_o=1, kind=0, id=1, addr=0x1000, resp=2; pop → err_valid_o=0.
- AR id=2 addr=0x2000 len=4; beat1 resp=2'b11, beats 2–4 OKAY, last on beat4 → exactly one record: kind=1, addr=0x2000, resp=3, logged after beat4.
- TimeoutCycles=8, AR id=0 addr=0x40 with no R → one kind-3 record after 8 cycles, none repeated; a later OKAY R last → queue empty, no new record.
- NumStoredErrors=2, DropOldest=0, three B errors with no pop → first two retained, drop_cnt_o=1; repeat with DropOldest=1 → records 2 and 3 retained.
- 5 AWs on id=3 with NumOutstanding=4 → track_ovf_o=1; B on an idle id=0 → unexp_rsp_o=1.
- Same cycle: B error id=0 and R-last error id=1 → one record, kind=0; drop_cnt_o=1.
